delta_weight_fetch_arbiter: RTL and testbench

//  Parametrised weight-fetch controller between PU_NUM weight buffers, the shared weight SRAM and DRAM.

---
 rtl/delta_weight_fetch_arbiter.sv | 134 +++++++++++++
 tb/tb_delta_weight_fetch_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_weight_fetch_arbiter.sv
// delta_weight_fetch_arbiter: round-robin weight fetch between PU buffers, weight SRAM and DRAM, with tile loop tracking.
// Option WFA_DRAM_FORWARD_EN: a DRAM fill grants straight after the SRAM write instead of re-reading SRAM.
module delta_weight_fetch_arbiter #(
    parameter int PU_NUM         = 8,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 10,
    parameter int IC_STEP        = 8,
    parameter int OC_STEP        = 8,
    parameter int ROW_STEP       = 8,
    parameter int COL_STEP       = 8,
    parameter int PU_SLICE_BYTES = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     finish_cycle,
    input  logic [CNT_W-1:0]         oc_num,
    input  logic [CNT_W-1:0]         ic_num,
    input  logic [CNT_W-1:0]         orc_size,
    input  logic [ADDR_W-1:0]        weight_base,
    input  logic [PU_NUM-1:0]        wb_req,
    input  logic [PU_NUM*ADDR_W-1:0] wb_addr,
    output logic [PU_NUM-1:0]        wb_grant,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic                     sram_w_en,
    output logic                     sram_r_en,
    input  logic                     sram_w_done,
    input  logic                     sram_d_ready,
    output logic                     dram_read,
    output logic [ADDR_W-1:0]        dram_addr,
    input  logic                     dram_ready,
    output logic                     busy,
    output logic                     layer_done
);
    localparam int PW = $clog2(PU_NUM);
    typedef enum logic [2:0] {IDLE, ARB, DRAM_RD, SRAM_WR, SRAM_RD, GRANT, ADVANCE} state_t;
`ifdef WFA_DRAM_FORWARD_EN
    localparam state_t WR_NEXT = GRANT;
`else
    localparam state_t WR_NEXT = SRAM_RD;
`endif
    state_t state, state_n;
    logic [PW-1:0] rr_ptr, g, pick, idx;
    logic [CNT_W-1:0] ic, col, row, oc;
    logic [CNT_W-1:0] eff_ic, eff_orc, eff_oc;
    logic [CNT_W:0] ic_s, col_s, row_s, oc_s;
    logic ic_w, col_w, row_w, oc_w, layer_wrap;
    logic [ADDR_W-1:0] tile_base, pick_addr;
    logic any_req, fin_pend;

    assign any_req = |wb_req;
    assign eff_ic  = {ic_num[CNT_W-1:3], 3'b000};
    assign eff_orc = {orc_size[CNT_W-1:3], 3'b000};
    assign eff_oc  = {oc_num[CNT_W-1:3], 3'b000};

    // Scan downward so the requester closest to rr_ptr is the one left standing.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = PU_NUM - 1; i >= 0; i--) begin
            idx = rr_ptr + PW'(i);
            if (wb_req[idx]) pick = idx;
        end
    end

    assign pick_addr = wb_addr[pick*ADDR_W +: ADDR_W] + ADDR_W'(pick) * ADDR_W'(PU_SLICE_BYTES) + tile_base;

    assign ic_s  = {1'b0, ic} + (CNT_W+1)'(IC_STEP);
    assign col_s = {1'b0, col} + (CNT_W+1)'(COL_STEP);
    assign row_s = {1'b0, row} + (CNT_W+1)'(ROW_STEP);
    assign oc_s  = {1'b0, oc} + (CNT_W+1)'(OC_STEP * PU_NUM);
    assign ic_w  = ic_s >= {1'b0, eff_ic};
    assign col_w = col_s >= {1'b0, eff_orc};
    assign row_w = row_s >= {1'b0, eff_orc};
    assign oc_w  = oc_s >= {1'b0, eff_oc};
    assign layer_wrap = ic_w && col_w && row_w && oc_w;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ARB;
            ARB:     if (any_req) state_n = (row == '0 && col == '0) ? DRAM_RD : SRAM_RD;
                     else if (finish_cycle || fin_pend) state_n = ADVANCE;
            DRAM_RD: if (dram_ready) state_n = SRAM_WR;
            SRAM_WR: if (sram_w_done) state_n = WR_NEXT;
            SRAM_RD: if (sram_d_ready) state_n = GRANT;
            GRANT:   state_n = ARB;
            ADVANCE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g          <= '0;
            ic         <= '0;
            col        <= '0;
            row        <= '0;
            oc         <= '0;
            tile_base  <= '0;
            fin_pend   <= 1'b0;
            sram_addr  <= '0;
            dram_addr  <= '0;
            layer_done <= 1'b0;
        end else begin
            state      <= state_n;
            layer_done <= 1'b0;
            if (state == ARB && any_req) begin
                g         <= pick;
                sram_addr <= pick_addr;
                dram_addr <= weight_base + pick_addr;
            end
            if (state == GRANT) rr_ptr <= g + 1'b1;
            if (state == ADVANCE) fin_pend <= 1'b0;
            else if (finish_cycle && (state != ARB || any_req)) fin_pend <= 1'b1;
            if (state == ADVANCE) begin
                ic <= ic_w ? '0 : ic_s[CNT_W-1:0];
                if (ic_w) col <= col_w ? '0 : col_s[CNT_W-1:0];
                if (ic_w && col_w) row <= row_w ? '0 : row_s[CNT_W-1:0];
                if (ic_w && col_w && row_w) oc <= oc_w ? '0 : oc_s[CNT_W-1:0];
                tile_base  <= layer_wrap ? '0 : tile_base + ADDR_W'(PU_NUM * PU_SLICE_BYTES);
                layer_done <= layer_wrap;
            end
        end
    end

    assign wb_grant  = (state == GRANT) ? PU_NUM'(1) << g : '0;
    assign dram_read = state == DRAM_RD;
    assign sram_w_en = state == SRAM_WR;
    assign sram_r_en = state == SRAM_RD;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_delta_weight_fetch_arbiter.sv
// tb_delta_weight_fetch_arbiter: randomized self-checking bench against a tile-index reference model.
module tb_delta_weight_fetch_arbiter;
    localparam int PU = 8;
    localparam int AW = 32;
    localparam int CW = 10;
`ifdef WFA_DRAM_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset, start, finish_cycle, sram_w_done, sram_d_ready, dram_ready;
    logic [CW-1:0] oc_num, ic_num, orc_size;
    logic [AW-1:0] weight_base;
    logic [PU-1:0] wb_req, wb_grant;
    logic [PU*AW-1:0] wb_addr;
    logic [AW-1:0] sram_addr, dram_addr;
    logic sram_w_en, sram_r_en, dram_read, busy, layer_done;
    int checks = 0;
    int passes = 0;
    int m_a, m_rr;

    delta_weight_fetch_arbiter dut (
        .clock(clock), .reset(reset), .start(start), .finish_cycle(finish_cycle),
        .oc_num(oc_num), .ic_num(ic_num), .orc_size(orc_size), .weight_base(weight_base),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_grant(wb_grant), .sram_addr(sram_addr),
        .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_w_done(sram_w_done),
        .sram_d_ready(sram_d_ready), .dram_read(dram_read), .dram_addr(dram_addr),
        .dram_ready(dram_ready), .busy(busy), .layer_done(layer_done)
    );

    always #5 clock = ~clock;

    // Number of distinct positions one loop level takes before it wraps.
    function automatic int levels(input int n, input int step);
        int e;
        e = n & ~7;
        return (e == 0) ? 1 : (e + step - 1) / step;
    endfunction

    function automatic int layer_len();
        return levels(ic_num, 8) * levels(orc_size, 8) * levels(orc_size, 8) * levels(oc_num, 64);
    endfunction

    function automatic bit m_fill();
        int nic, ncol, nrow;
        nic  = levels(ic_num, 8);
        ncol = levels(orc_size, 8);
        nrow = levels(orc_size, 8);
        return ((m_a / nic) % ncol == 0) && ((m_a / (nic * ncol)) % nrow == 0);
    endfunction

    function automatic int m_pick(input logic [PU-1:0] p);
        for (int i = 0; i < PU; i++) if (p[(m_rr + i) % PU]) return (m_rr + i) % PU;
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; finish_cycle = 1'b0; wb_req = '0;
        sram_w_done = 1'b0; sram_d_ready = 1'b0; dram_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_a = 0;
        m_rr = 0;
    endtask

    // mode 0: finish after all grants; 1: finish in first ARB cycle; 2: finish mid-transfer
    task automatic run_cycle(input logic [PU-1:0] mask, input int mode);
        logic [PU-1:0] pending;
        logic [AW-1:0] exp_addr;
        bit fill, exp_ld, saw_d, saw_w, saw_r, done, fin_now;
        int g;
        pending = mask;
        fill = m_fill();
        exp_ld = ((m_a + 1) % layer_len()) == 0;
        fin_now = (mode == 2);
        @(negedge clock);
        start = 1'b1;
        wb_req = mask;
        @(negedge clock);
        start = 1'b0;
        finish_cycle = (mode == 1);
        while (pending != '0) begin
            g = m_pick(pending);
            exp_addr = wb_addr[g*AW +: AW] + 32'(g * 256) + 32'(m_a * 2048);
            saw_d = 0; saw_w = 0; saw_r = 0; done = 0;
            for (int c = 0; c < 80 && !done; c++) begin
                @(negedge clock);
                finish_cycle = fin_now;
                fin_now = 1'b0;
                if (dram_read && !saw_d) begin
                    checks++;
                    if (dram_addr !== weight_base + exp_addr)
                        $display("FAIL dram_addr pu%0d: got %h want %h", g, dram_addr, weight_base + exp_addr);
                    else passes++;
                end
                saw_d |= dram_read;
                saw_w |= sram_w_en;
                saw_r |= sram_r_en;
                dram_ready   = dram_read && ($urandom_range(0, 2) != 0);
                sram_w_done  = sram_w_en && ($urandom_range(0, 2) != 0);
                sram_d_ready = sram_r_en && ($urandom_range(0, 2) != 0);
                if (wb_grant != '0) begin
                    done = 1;
                    checks++;
                    if (wb_grant !== PU'(1) << g) $display("FAIL grant: got %b want pu%0d", wb_grant, g);
                    else passes++;
                    checks++;
                    if (sram_addr !== exp_addr) $display("FAIL sram_addr pu%0d: got %h want %h", g, sram_addr, exp_addr);
                    else passes++;
                    checks++;
                    if ({saw_d, saw_w, saw_r} !== {fill, fill, !fill || !FWD})
                        $display("FAIL path pu%0d: got dram/wr/rd=%b%b%b want fill=%0b", g, saw_d, saw_w, saw_r, fill);
                    else passes++;
                    pending[g] = 1'b0;
                    wb_req[g] = 1'b0;
                    m_rr = (g + 1) % PU;
                    dram_ready = 1'b0; sram_w_done = 1'b0; sram_d_ready = 1'b0;
                end
            end
            if (!done) begin
                checks++;
                $display("FAIL grant_timeout pu%0d: got no grant want one", g);
                wb_req = '0;
                finish_cycle = 1'b0;
                return;
            end
            @(negedge clock);
            checks++;
            if (wb_grant !== '0) $display("FAIL grant_len: got %b want 0", wb_grant);
            else passes++;
        end
        if (mode == 0 || (mode == 2 && mask == '0)) begin
            finish_cycle = 1'b1;
            @(negedge clock);
            finish_cycle = 1'b0;
        end else if (mode == 1 && mask == '0) begin
            @(negedge clock);
            finish_cycle = 1'b0;
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clock);
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_timeout: busy got %b want 0", busy);
        else passes++;
        checks++;
        if (layer_done !== exp_ld) $display("FAIL layer_done a=%0d: got %b want %b", m_a, layer_done, exp_ld);
        else passes++;
        @(negedge clock);
        checks++;
        if (layer_done !== 1'b0) $display("FAIL layer_done_pulse: got %b want 0", layer_done);
        else passes++;
        m_a = (m_a + 1) % layer_len();
    endtask

    task automatic test_reset();
        weight_base = 32'h1000_0000;
        apply_reset();
        checks++;
        if ({wb_grant, sram_addr, dram_addr} !== '0)
            $display("FAIL reset_data: got grant %b sram %h dram %h want 0", wb_grant, sram_addr, dram_addr);
        else passes++;
        checks++;
        if ({sram_w_en, sram_r_en, dram_read, busy, layer_done} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000", {sram_w_en, sram_r_en, dram_read, busy, layer_done});
        else passes++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < PU; i++) wb_addr[i*AW +: AW] = $urandom_range(0, 255);
        run_cycle(8'hFF, 0);
        run_cycle(8'hA5, 0);
    endtask

    task automatic test_fill();
        apply_reset();
        wb_addr = '0;
        wb_addr[2*AW +: AW] = 32'h10;
        run_cycle(8'h04, 0);
    endtask

    task automatic test_hit_path();
        apply_reset();
        run_cycle(8'h81, 0);
        run_cycle(8'h3C, 2);
        run_cycle(8'h42, 0);
    endtask

    task automatic test_finish_race();
        apply_reset();
        wb_addr = '0;
        run_cycle(8'h01, 1);
        run_cycle(8'h01, 1);
        run_cycle(8'h00, 1);
    endtask

    task automatic test_loop_wrap();
        ic_num = 10'd16; orc_size = 10'd8; oc_num = 10'd64;
        apply_reset();
        for (int i = 0; i < 3; i++) run_cycle(PU'($urandom_range(1, 255)), 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        seen = 0;
        @(negedge clock);
        start = 1'b1;
        wb_req = 8'h01;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = dram_read;
        end
        checks++;
        if (!seen) $display("FAIL mid_dram_read: got 0 want 1");
        else passes++;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({dram_read, sram_w_en, sram_r_en, busy, wb_grant} !== '0)
            $display("FAIL mid_reset: got rd/w/r/busy %b%b%b%b grant %b want 0", dram_read, sram_w_en, sram_r_en, busy, wb_grant);
        else passes++;
        reset = 1'b0;
        wb_req = '0;
        m_a = 0;
        m_rr = 0;
        run_cycle(8'h01, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            ic_num = CW'($urandom_range(0, 40));
            orc_size = CW'($urandom_range(0, 30));
            oc_num = CW'($urandom_range(0, 200));
            weight_base = $urandom;
            apply_reset();
            for (int n = 0; n < 10; n++) begin
                for (int i = 0; i < PU; i++) wb_addr[i*AW +: AW] = $urandom;
                run_cycle(($urandom_range(0, 3) == 0) ? '0 : PU'($urandom), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish_cycle = 1'b0; wb_req = '0; wb_addr = '0;
        sram_w_done = 1'b0; sram_d_ready = 1'b0; dram_ready = 1'b0;
        ic_num = 10'd8; orc_size = 10'd21; oc_num = 10'd67; weight_base = '0;
        test_reset();
        test_round_robin();
        test_fill();
        test_hit_path();
        test_finish_race();
        test_reset_mid();
        test_loop_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
